// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned RegAddrW = 5;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select for one source operand.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [RegAddrW-1:0] rs_e_i,
    input  logic [RegAddrW-1:0] rd_m_i,
    input  logic                reg_write_m_i,
    input  logic [RegAddrW-1:0] rd_w_i,
    input  logic                reg_write_w_i,
    output logic [1:0]          fwd_o
);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        fwd_o = FWD_NONE;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, forwarding and memory-wait timeout.
// Define HAZARD_PERF_EN to add the stall_cycles / flush_count performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RegAddrW-1:0] Rs1D,
    input  logic [RegAddrW-1:0] Rs2D,
    input  logic [RegAddrW-1:0] Rs1E,
    input  logic [RegAddrW-1:0] Rs2E,
    input  logic [RegAddrW-1:0] RdE,
    input  logic                MemReadE,
    input  logic                RegWriteE,
    input  logic [RegAddrW-1:0] RdM,
    input  logic                RegWriteM,
    input  logic                MemReqM,
    input  logic                mem_ready,
    input  logic [RegAddrW-1:0] RdW,
    input  logic                RegWriteW,
    input  logic                PCSrcE,
    output logic                StallF,
    output logic                StallD,
    output logic                StallE,
    output logic                StallM,
    output logic                FlushD,
    output logic                FlushE,
    output logic                FlushW,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                mem_timeout_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         flush_count
`endif
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);
    localparam logic [CntW-1:0] CntErr = CntW'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            load_use, mem_wait;
    logic [1:0]      fwd_a, fwd_b;
    logic            unused_regwrite_e;

    assign unused_regwrite_e = RegWriteE;

    assign load_use = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_wait = MemReqM && !mem_ready;

    // A redirect during mem_wait is deferred: EX is frozen and keeps PCSrcE asserted.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_wait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    forward_unit u_fwd_a (
        .rs_e_i        (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_e_i        (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_b)
    );

    assign ForwardAE = rst ? FWD_NONE : fwd_a;
    assign ForwardBE = rst ? FWD_NONE : fwd_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    if (cnt_d >= CntErr) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (FlushD) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4): vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

    // Expected bundle: {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, FwdA[1:0], FwdB[1:0], err}
    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       mre;
        logic [4:0] rdm;
        logic       rwm, mreq, mrdy;
        logic [4:0] rdw;
        logic       rww, pc;
        logic [11:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic       MemReadE = 1'b0, RegWriteE = 1'b0, RegWriteM = 1'b0, MemReqM = 1'b0;
    logic       mem_ready = 1'b1, RegWriteW = 1'b0, PCSrcE = 1'b0;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout_err;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] exp_q[$];
    string       name_q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .Rs1D            (Rs1D),
        .Rs2D            (Rs2D),
        .Rs1E            (Rs1E),
        .Rs2E            (Rs2E),
        .RdE             (RdE),
        .MemReadE        (MemReadE),
        .RegWriteE       (RegWriteE),
        .RdM             (RdM),
        .RegWriteM       (RegWriteM),
        .MemReqM         (MemReqM),
        .mem_ready       (mem_ready),
        .RdW             (RdW),
        .RegWriteW       (RegWriteW),
        .PCSrcE          (PCSrcE),
        .StallF          (StallF),
        .StallD          (StallD),
        .StallE          (StallE),
        .StallM          (StallM),
        .FlushD          (FlushD),
        .FlushE          (FlushE),
        .FlushW          (FlushW),
        .ForwardAE       (ForwardAE),
        .ForwardBE       (ForwardBE),
        .mem_timeout_err (mem_timeout_err)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    function automatic vec_t mk(string name, logic r, logic [4:0] rs1d, logic [4:0] rs2d,
                                logic [4:0] rs1e, logic [4:0] rs2e, logic [4:0] rde,
                                logic mre, logic [4:0] rdm, logic rwm, logic mreq,
                                logic mrdy, logic [4:0] rdw, logic rww, logic pc,
                                logic [11:0] exp);
        vec_t v;
        v.name = name; v.rst = r; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e;
        v.rs2e = rs2e; v.rde = rde; v.mre = mre; v.rdm = rdm; v.rwm = rwm;
        v.mreq = mreq; v.mrdy = mrdy; v.rdw = rdw; v.rww = rww; v.pc = pc; v.exp = exp;
        return v;
    endfunction

    // Drive just after posedge, queue the expectation, compare at the following negedge.
    task automatic step(input vec_t v);
        logic [11:0] got, want;
        string       nm;
        @(posedge clk);
        #1;
        rst = v.rst; Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
        MemReadE = v.mre; RdM = v.rdm; RegWriteM = v.rwm; MemReqM = v.mreq;
        mem_ready = v.mrdy; RdW = v.rdw; RegWriteW = v.rww; PCSrcE = v.pc;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge clk);
        got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, mem_timeout_err};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %b", v.name, got);
        end else begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s: got %b required %b (SFDEM_FDEW_AA_BB_err)", nm, got, want);
            end
        end
    endtask

    initial begin
        //          name             r rs1d rs2d rs1e rs2e rde mre rdm rwm mreq rdy rdw rww pc  exp
        tbl.push_back(mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 12'b0000_000_00_00_0));
        tbl.push_back(mk("lu_rs1",     0, 5, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0, 12'b1100_010_00_00_0));
        tbl.push_back(mk("lu_release", 0, 5, 0, 5, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 12'b0000_000_10_00_0));
        tbl.push_back(mk("lu_rs2",     0, 3, 5, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0, 12'b1100_010_00_00_0));
        tbl.push_back(mk("ld_x0",      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 12'b0000_000_00_00_0));
        tbl.push_back(mk("ld_nomatch", 0, 6, 7, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0, 12'b0000_000_00_00_0));
        tbl.push_back(mk("nonload",    0, 5, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 12'b0000_000_00_00_0));
        tbl.push_back(mk("pc_lu",      0, 5, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 1, 12'b0000_110_00_00_0));
        tbl.push_back(mk("pc_only",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 12'b0000_110_00_00_0));
        tbl.push_back(mk("fwd_mem_win",0, 0, 0, 7, 0, 0, 0, 7, 1, 0, 1, 7, 1, 0, 12'b0000_000_10_00_0));
        tbl.push_back(mk("fwd_wb",     0, 0, 0, 7, 0, 0, 0, 7, 0, 0, 1, 7, 1, 0, 12'b0000_000_01_00_0));
        tbl.push_back(mk("fwd_x0",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 12'b0000_000_00_00_0));
        tbl.push_back(mk("fwd_b_mem",  0, 0, 0, 3, 9, 0, 0, 9, 1, 0, 1, 3, 1, 0, 12'b0000_000_01_10_0));
        tbl.push_back(mk("fwd_b_wb",   0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1, 4, 1, 0, 12'b0000_000_00_01_0));
        tbl.push_back(mk("fwd_nowr",   0, 0, 0, 7, 7, 0, 0, 7, 0, 0, 1, 7, 0, 0, 12'b0000_000_00_00_0));

        step(mk("reset",        1, 0, 0, 7, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 12'b0000_111_00_00_0));
        foreach (tbl[i]) step(tbl[i]);

        // Memory wait of 3 cycles; a redirect stays deferred until ready.
        step(mk("mw1",          0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 12'b1111_001_00_00_0));
        step(mk("mw2_pc",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 12'b1111_001_00_00_0));
        step(mk("mw3_fwd",      0, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0, 7, 1, 1, 12'b1111_001_01_00_0));
        step(mk("mw_ready_pc",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 12'b0000_110_00_00_0));
        step(mk("mw_after",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 12'b0000_000_00_00_0));

        // Timeout: ready low for 6 cycles, err visible from the 5th.
        for (int i = 1; i <= 6; i++) begin
            step(mk($sformatf("to_wait%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,
                    (i >= 5) ? 12'b1111_001_00_00_1 : 12'b1111_001_00_00_0));
        end
        step(mk("to_ready",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 12'b0000_000_00_00_1));
        step(mk("to_sticky",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 12'b0000_000_00_00_1));
        step(mk("to_wait_again",0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 12'b1111_001_00_00_1));

        // Asynchronous reset while in MEM_WAIT clears err and forces the clear-pipeline outputs.
        step(mk("rst_mid_wait", 1, 0, 0, 7, 0, 5, 1, 7, 1, 1, 0, 0, 0, 1, 12'b0000_111_00_00_0));
        step(mk("rst_hold",     1, 5, 0, 7, 0, 5, 1, 7, 1, 1, 0, 0, 0, 0, 12'b0000_111_00_00_0));
        step(mk("post_rst",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 12'b0000_000_00_00_0));

        // Fresh counter after reset: 3-cycle wait must not time out.
        for (int i = 1; i <= 3; i++) begin
            step(mk($sformatf("fresh_wait%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,
                    12'b1111_001_00_00_0));
        end
        step(mk("fresh_ready",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 12'b0000_000_00_00_0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
